uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 UART_tx.
- Frame format is configurable: data width, parity mode, stop-bit count and baud divisor.
- A small transmit FIFO lets a host queue several bytes and have them sent back-to-back with no idle gap.
- Sits between command/response logic and the serial TX pin.
- Keeps the trmt/tx_data/tx_done/TX handshake the rest of the design already uses.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
BAUD_DIV, 2604, clocks per bit period (50 MHz / 19200 baud); must be ≥ 2.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 4, transmit FIFO entries; power of 2, ≥ 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
trmt  input  1  push request: tx_data is written to the FIFO at this edge if not full.
tx_data  input  DATA_BITS  word to queue.
tx_done  output  1  sticky: last queued frame has finished transmitting.
TX  output  1  serial line, idle high; registered.
tx_busy  output  1  high while a frame is on the line (any state except IDLE).
fifo_full  output  1  FIFO count == FIFO_DEPTH.
ovf  output  1  sticky: a trmt was dropped because the FIFO was full.

Behaviour:
Reset (asynchronous):
- Outputs: TX=1, tx_done=0, tx_busy=0, fifo_full=0, ovf=0.
- FIFO emptied, FSM to IDLE, baud and bit counters zeroed.
- Reset asserted mid-frame drives TX high immediately; the partial frame and all queued words are discarded.

FIFO:
- Circular buffer with registered count; fifo_full is decoded from the count.
- Push on trmt && !fifo_full.
- trmt while full: the word is dropped and ovf is set. This holds even if a pop occurs on the same edge, because the full test uses the pre-edge count.
- A simultaneous push and pop leaves the count unchanged.
- ovf clears only on reset.

FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: TX=1. FIFO non-empty → pop head into shift register, zero the baud counter, go to START; TX=0 from that edge.
- Latency: trmt sampled at edge N into an empty FIFO with FSM idle → TX falls at edge N+1.
- Every bit state lasts exactly BAUD_DIV clocks, counted by a baud counter 0..BAUD_DIV-1.
- START → DATA.
- DATA: DATA_BITS bits, LSB first; shift on each bit boundary.
- After the last data bit → PAR if PARITY≠0, else STOP.
- PAR bit value:
  - even mode: XOR of the frame's data bits;
  - odd mode: inverse of that XOR.
  - Parity is computed from the popped word, never from live tx_data.
- STOP: TX=1 for STOP_BITS×BAUD_DIV clocks.
- At the end of STOP:
  - FIFO non-empty → pop and go straight to START (TX=0 on the next edge, no idle bit);
  - FIFO empty → IDLE and set tx_done.
- tx_done clears on any accepted push. A push on the same edge tx_done would be set takes priority, leaving tx_done=0.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV clocks.
- tx_data and trmt may change freely during a frame; queued words are unaffected.

Test Plan:
1. BAUD_DIV=16, defaults otherwise.
   - Push 0xAA at edge N → TX low at edge N+1 for 16 clocks.
   - Bits 0,1,0,1,0,1,0,1 (16 clocks each), then 16 clocks high.
   - tx_done rises 160 clocks after TX fell; tx_busy falls on the same edge.
2. PARITY=1, then PARITY=2, send 0xA5 (four ones) → parity bit 0 for even, 1 for odd.
   - Frame length 176 clocks at BAUD_DIV=16.
3. FIFO_DEPTH=4, BAUD_DIV=16, push 0x11,0x22,0x33,0x44,0x55,0x66 on six consecutive cycles from idle.
   - 0x11 pops at once; 0x22..0x55 fill the FIFO; fifo_full is high after the fifth push.
   - 0x66 is dropped and ovf=1.
   - Five frames go out back-to-back with no high gap between stop and start bits.
   - tx_done is set only after 0x55.
4. STOP_BITS=2, DATA_BITS=7, send 0x7F → start bit, seven 1s, then two stop bits (32 clocks high); frame = 160 clocks.
5. Reset mid-frame: assert rst_n=0 during data bit 3 of 0xCC with two words queued.
   - TX=1 and tx_busy=0 asynchronously.
   - After release, the FIFO is empty and no frame starts without a new trmt.
6. tx_done clear: after a completed frame (tx_done=1), push 0x3C.
   - tx_done goes low on that edge and stays low until that frame's stop bit ends.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small transmit FIFO in front of it.
// Queued words are sent back-to-back; TX is registered and idles high.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_done,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 fifo_full,
    output logic                 ovf
);
    // state | meaning
    // IDLE  | line high, waiting for a queued word
    // START | start bit, line low
    // DATA  | data bits, LSB first
    // PAR   | parity bit, only visited when PARITY != 0
    // STOP  | stop bit(s), line high
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(BAUD_DIV);

    state_t                 state, state_next;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   push, pop, fifo_empty;
    logic [BW-1:0]          baud_cnt;
    logic                   baud_end;
    logic [3:0]             bit_cnt;
    logic                   data_last, stop_last;
    logic [DATA_BITS-1:0]   shreg, sh_next;
    logic                   par_bit;
    logic                   tx_next;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // Full test uses the pre-edge count, so a same-edge pop never rescues a push.
    assign push       = trmt && !fifo_full;
    assign baud_end   = (baud_cnt == BW'(BAUD_DIV - 1));
    assign data_last  = (bit_cnt == 4'(DATA_BITS - 1));
    assign stop_last  = (bit_cnt == 4'(STOP_BITS - 1));
    assign tx_busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (trmt && fifo_full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: if (baud_end) state_next = DATA;
            DATA: begin
                if (baud_end && data_last) state_next = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (baud_end) state_next = STOP;
            STOP: begin
                if (baud_end && stop_last) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sh_next = shreg;
        if (pop)                           sh_next = mem[rd_ptr];
        else if (state == DATA && baud_end) sh_next = shreg >> 1;
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_next[0];
            PAR:     tx_next = par_bit;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX       <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_done  <= 1'b0;
        end else begin
            TX    <= tx_next;
            shreg <= sh_next;
            if (pop) par_bit <= (^mem[rd_ptr]) ^ (PARITY == 2);
            if (state == IDLE || baud_end) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;
            if (state_next != state) bit_cnt <= '0;
            else if (baud_end)       bit_cnt <= bit_cnt + 1'b1;
            if (push)                                    tx_done <= 1'b0;
            else if (state == STOP && state_next == IDLE) tx_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three differently-configured instances share one stimulus
// stream and are compared every cycle against a frame-level line model.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       trmt = 1'b0;
    logic [8:0] tx_data = '0;
    logic [2:0] tx_o, busy_o, done_o, full_o, ovf_o;

    int n_checks = 0;
    int n_errs   = 0;

    int db  [3] = '{8, 7, 9};
    int bd  [3] = '{16, 5, 2};
    int par [3] = '{1, 2, 0};
    int sb  [3] = '{1, 2, 1};
    int dep [3] = '{4, 2, 8};

    int       fw [3][16];
    int       fhead [3], fcnt [3], pos [3], flen [3];
    bit       act [3], m_done [3], m_ovf [3];
    bit [15:0] fb [3];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data[7:0]),
        .tx_done(done_o[0]), .TX(tx_o[0]), .tx_busy(busy_o[0]), .fifo_full(full_o[0]), .ovf(ovf_o[0]));
    uart_tx_fifo #(.DATA_BITS(7), .BAUD_DIV(5), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data[6:0]),
        .tx_done(done_o[1]), .TX(tx_o[1]), .tx_busy(busy_o[1]), .fifo_full(full_o[1]), .ovf(ovf_o[1]));
    uart_tx_fifo #(.DATA_BITS(9), .BAUD_DIV(2), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
        .tx_done(done_o[2]), .TX(tx_o[2]), .tx_busy(busy_o[2]), .fifo_full(full_o[2]), .ovf(ovf_o[2]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            fhead[i] = 0; fcnt[i] = 0; pos[i] = 0; flen[i] = 0;
            act[i] = 0; m_done[i] = 0; m_ovf[i] = 0; fb[i] = '0;
        end
    endfunction

    // A frame is a list of line bits: start, data LSB first, optional parity, stop bits.
    function automatic void build_frame(input int i, input int w);
        int n = 0;
        fb[i] = '0;
        fb[i][n++] = 1'b0;
        for (int k = 0; k < db[i]; k++) fb[i][n++] = w[k];
        if (par[i] != 0) fb[i][n++] = ($countones(w) % 2 == 1) ^ (par[i] == 2);
        for (int s = 0; s < sb[i]; s++) fb[i][n++] = 1'b1;
        flen[i] = n;
    endfunction

    function automatic void model_step(input bit t, input int d);
        for (int i = 0; i < 3; i++) begin
            bit push_ok, ended;
            int tail, pop_now;
            push_ok = t && (fcnt[i] < dep[i]);
            if (t && !push_ok) m_ovf[i] = 1;
            tail  = (fhead[i] + fcnt[i]) % dep[i];
            ended = 0;
            if (act[i]) begin
                pos[i]++;
                if (pos[i] == flen[i] * bd[i]) begin
                    act[i] = 0;
                    ended  = 1;
                end
            end
            pop_now = (!act[i] && fcnt[i] > 0) ? 1 : 0;
            if (pop_now != 0) begin
                build_frame(i, fw[i][fhead[i]]);
                fhead[i] = (fhead[i] + 1) % dep[i];
                act[i]   = 1;
                pos[i]   = 0;
            end
            if (push_ok) fw[i][tail] = d & ((1 << db[i]) - 1);
            fcnt[i] = fcnt[i] + int'(push_ok) - pop_now;
            if (ended && pop_now == 0) m_done[i] = 1;
            if (push_ok) m_done[i] = 0;
        end
    endfunction

    function automatic bit m_idle();
        for (int i = 0; i < 3; i++) if (act[i] || fcnt[i] != 0) return 0;
        return 1;
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("tx[%0d]", i),   tx_o[i],   act[i] ? fb[i][pos[i] / bd[i]] : 1'b1);
            check_val($sformatf("busy[%0d]", i), busy_o[i], act[i]);
            check_val($sformatf("done[%0d]", i), done_o[i], m_done[i]);
            check_val($sformatf("full[%0d]", i), full_o[i], fcnt[i] == dep[i]);
            check_val($sformatf("ovf[%0d]", i),  ovf_o[i],  m_ovf[i]);
        end
    endtask

    task automatic step(input bit t, input logic [8:0] d);
        trmt    = t;
        tx_data = d;
        @(posedge clk);
        if (rst_n) model_step(t, int'(d));
        @(negedge clk);
        check_all();
    endtask

    task automatic run_idle(input int max_cyc);
        int n = 0;
        while ((!m_idle() || busy_o != 3'b000) && n < max_cyc) begin
            step(1'b0, 9'($urandom));
            n++;
        end
        if (n >= max_cyc) check_val("idle_timeout", n, 0);
        repeat (3) step(1'b0, 9'($urandom));
    endtask

    initial begin
        logic [8:0] burst [6];
        burst = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 9'h0AA); run_idle(2000);
        step(1'b1, 9'h0A5); run_idle(2000);
        foreach (burst[k]) step(1'b1, burst[k]);
        run_idle(3000);
        step(1'b1, 9'h07F); run_idle(2000);
        step(1'b1, 9'h03C); run_idle(2000);

        // Second push lands on the edge where instance C's frame would set tx_done.
        step(1'b1, 9'h155);
        repeat (22) step(1'b0, 9'h1FF);
        step(1'b1, 9'h0F0);
        run_idle(2000);

        step(1'b1, 9'h0CC); step(1'b1, 9'h001); step(1'b1, 9'h002);
        repeat (62) step(1'b0, 9'($urandom));
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        repeat (3) step(1'b0, 9'($urandom));
        rst_n = 1'b1;
        repeat (300) step(1'b0, 9'($urandom));

        for (int ph = 0; ph < 4; ph++) begin
            int p;
            p = (ph % 2 == 1) ? 40 : 4;
            repeat (1500) step($urandom_range(0, 99) < p, 9'($urandom));
        end
        run_idle(3000);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
